// File: rtl/fir1d_mac_seq.sv
// ---------------------------------------------------------------------------
// fir1d_mac_seq
//
// Sequential 1-D FIR tap: captures a packed window of BufferSize signed
// samples and a packed vector of signed coefficients, then accumulates
// sum(tap[i] * coeff[i]) through one shared multiplier, one tap per cycle.
// The full-precision sum and a FracBits-rescaled sample are presented with a
// one-cycle d_valid strobe.
//
// Optional build macro: FIR1D_ROUND_SAT_EN
//   undefined : d_out = (acc >>> FracBits) truncated to DataBitWidth (wraps)
//   defined   : d_out = round-half-up(acc / 2^FracBits), saturated to the
//               sample range; adds the sticky sat_flag output.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   request, sampled only while idle
//   window   in   BufferSize packed signed taps, tap 0 (oldest) in the LSBs
//   coeff    in   BufferSize packed signed coefficients, same packing
//   busy     out  high while a request is being processed (MAC and DONE)
//   d_valid  out  one-cycle strobe, d_out/acc_out carry a new result
//   d_out    out  scaled result, held until the next result
//   acc_out  out  full-precision sum, held until the next result
//   sat_flag out  (FIR1D_ROUND_SAT_EN only) last result was clamped
// ---------------------------------------------------------------------------
module fir1d_mac_seq #(
    parameter int DataBitWidth  = 12,
    parameter int BufferSize    = 5,
    parameter int CoeffBitWidth = 8,
    parameter int FracBits      = 6,
    localparam int AccWidth     = DataBitWidth + CoeffBitWidth + $clog2(BufferSize)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [BufferSize*DataBitWidth-1:0]    window,
    input  logic [BufferSize*CoeffBitWidth-1:0]   coeff,
    output logic                                  busy,
    output logic                                  d_valid,
    output logic [DataBitWidth-1:0]               d_out,
    output logic [AccWidth-1:0]                   acc_out
`ifdef FIR1D_ROUND_SAT_EN
    ,
    output logic                                  sat_flag
`endif
);

    localparam int CntWidth  = $clog2(BufferSize);
    localparam int ProdWidth = DataBitWidth + CoeffBitWidth;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CntWidth-1:0] LAST_TAP = CntWidth'(BufferSize - 1);

`ifdef FIR1D_ROUND_SAT_EN
    // One extra bit so adding the rounding half can never overflow.
    localparam logic signed [AccWidth:0] HALF    = (AccWidth+1)'(1) << (FracBits - 1);
    localparam logic signed [AccWidth:0] SAT_MAX = (AccWidth+1)'((2 ** (DataBitWidth - 1)) - 1);
    localparam logic signed [AccWidth:0] SAT_MIN = ~SAT_MAX;
`endif

    logic [1:0]                                state_q, state_d;
    logic [CntWidth-1:0]                       cnt_q, cnt_d;
    logic signed [AccWidth-1:0]                acc_q, acc_d;
    logic [BufferSize*DataBitWidth-1:0]        win_q, win_d;
    logic [BufferSize*CoeffBitWidth-1:0]       coef_q, coef_d;
    logic                                      d_valid_q, d_valid_d;
    logic [DataBitWidth-1:0]                   d_out_q, d_out_d;
    logic [AccWidth-1:0]                       acc_out_q, acc_out_d;

    logic signed [DataBitWidth-1:0]            tap_s;
    logic signed [CoeffBitWidth-1:0]           cf_s;
    logic signed [ProdWidth-1:0]               prod_s;

`ifdef FIR1D_ROUND_SAT_EN
    logic                                      sat_q, sat_d;
    logic signed [AccWidth:0]                  rnd_s;
    logic signed [AccWidth:0]                  rsh_s;
`endif

    // Shared multiplier operand select and product of the current tap.
    always_comb begin
        tap_s  = win_q[int'(cnt_q)*DataBitWidth +: DataBitWidth];
        cf_s   = coef_q[int'(cnt_q)*CoeffBitWidth +: CoeffBitWidth];
        prod_s = $signed({{CoeffBitWidth{tap_s[DataBitWidth-1]}}, tap_s})
               * $signed({{DataBitWidth{cf_s[CoeffBitWidth-1]}}, cf_s});
    end

`ifdef FIR1D_ROUND_SAT_EN
    // Round half up before the arithmetic shift.
    always_comb begin
        rnd_s = $signed({acc_q[AccWidth-1], acc_q}) + HALF;
        rsh_s = rnd_s >>> FracBits;
    end
`endif

    // FSM next-state, accumulator and output-register next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        win_d     = win_q;
        coef_d    = coef_q;
        d_valid_d = 1'b0;
        d_out_d   = d_out_q;
        acc_out_d = acc_out_q;
`ifdef FIR1D_ROUND_SAT_EN
        sat_d     = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_d   = window;
                    coef_d  = coeff;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + {{(AccWidth-ProdWidth){prod_s[ProdWidth-1]}}, prod_s};
                if (cnt_q == LAST_TAP) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CntWidth'(1);
                end
            end
            ST_DONE: begin
                acc_out_d = acc_q;
                d_valid_d = 1'b1;
                state_d   = ST_IDLE;
`ifdef FIR1D_ROUND_SAT_EN
                if (rsh_s > SAT_MAX) begin
                    d_out_d = SAT_MAX[DataBitWidth-1:0];
                    sat_d   = 1'b1;
                end else if (rsh_s < SAT_MIN) begin
                    d_out_d = SAT_MIN[DataBitWidth-1:0];
                    sat_d   = 1'b1;
                end else begin
                    d_out_d = rsh_s[DataBitWidth-1:0];
                    sat_d   = 1'b0;
                end
`else
                // acc >>> FracBits keeping the low DataBitWidth bits is just
                // this bit slice of the accumulator.
                d_out_d = acc_q[FracBits +: DataBitWidth];
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            win_q     <= '0;
            coef_q    <= '0;
            d_valid_q <= 1'b0;
            d_out_q   <= '0;
            acc_out_q <= '0;
`ifdef FIR1D_ROUND_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            win_q     <= win_d;
            coef_q    <= coef_d;
            d_valid_q <= d_valid_d;
            d_out_q   <= d_out_d;
            acc_out_q <= acc_out_d;
`ifdef FIR1D_ROUND_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign d_valid = d_valid_q;
    assign d_out   = d_out_q;
    assign acc_out = acc_out_q;
`ifdef FIR1D_ROUND_SAT_EN
    assign sat_flag = sat_q;
`endif

endmodule

// File: doc/fir1d_mac_seq.md
Name: fir1d_mac_seq

Overview:
- Downstream consumer of the 1-D sample buffer. It takes the packed BufferSize-tap window and a packed coefficient vector, and computes one signed dot product (a FIR output sample) with a single shared multiplier iterated over the taps.
- Controlled by a start/busy/valid handshake, so the upstream buffer may shift as soon as the window has been captured.
- Output is rescaled by FracBits to the sample width for the next CFA interpolation stage.

Parameters:
- DataBitWidth, 12, signed sample width; one tap of the window.
- BufferSize, 5, number of taps; must be >= 2.
- CoeffBitWidth, 8, signed coefficient width.
- FracBits, 6, coefficient fractional bits; 1.0 == 2^FracBits. Must be < CoeffBitWidth.
- (localparam) AccWidth = DataBitWidth+CoeffBitWidth+clog2(BufferSize); 23 with defaults.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- window  in  BufferSize*DataBitWidth  signed taps; tap i = bits [(i+1)*DataBitWidth-1 : i*DataBitWidth], tap 0 = oldest.
- coeff  in  BufferSize*CoeffBitWidth  signed coefficients; same packing, coeff i weights tap i.
- busy  out  1  high in MAC and DONE.
- d_valid  out  1  one-cycle strobe; d_out and acc_out are valid.
- d_out  out  DataBitWidth  signed, scaled result; held until the next result.
- acc_out  out  AccWidth  signed, full-precision sum; held until the next result.

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, and overrides every other input including start:
  - state=IDLE, busy=0, d_valid=0, d_out=0, acc_out=0.
  - Accumulator and tap counter cleared.
- States: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - busy=0.
  - On start=1: register window and coeff into internal copies, acc=0, cnt=0, go to MAC.
  - Inputs may change freely after the capture edge.
- MAC:
  - Each cycle: acc <= acc + sext(tap[cnt]) * sext(coeff[cnt]), signed full-width; cnt++.
  - When cnt==BufferSize-1 the final product is added and the FSM goes to DONE.
  - Exactly BufferSize MAC cycles per request.
- DONE:
  - acc_out <= acc; d_out <= scaled(acc); d_valid=1 for this one cycle; go to IDLE.
- Latency: start sampled at edge T -> d_valid high in the cycle after edge T+BufferSize+1. Minimum start-to-start spacing is BufferSize+2 cycles.
- start while busy=1 is ignored, with no queuing. start held high re-arms on the first IDLE cycle.
- Arithmetic:
  - The accumulator cannot overflow: AccWidth covers the worst case.
  - scaled(acc), default build: acc >>> FracBits (arithmetic shift, truncation toward -inf), then the low DataBitWidth bits, which wrap.
- Reset mid-operation: the computation in progress is discarded. No d_valid is produced for it and the previous d_out is cleared to 0.
- d_valid is never asserted except in DONE.

Optional Feature:
- Macro: FIR1D_ROUND_SAT_EN
- Defined: scaled(acc) = (acc + 2^(FracBits-1)) >>> FracBits (round half up), then saturated to [-2^(DataBitWidth-1), 2^(DataBitWidth-1)-1].
  - Adds a 1-bit sticky output port sat_flag. It is set in DONE when clamping occurred, cleared in DONE otherwise, and reset to 0.
- Undefined: truncating shift with wrap as above; no sat_flag port.
- Latency and handshake are identical in both builds.

Test Plan:
1. Reset, then idle: busy=0, d_valid=0, d_out=0, acc_out=0 for 10 cycles with start=0.
2. window=[100,200,300,400,500], coeff all 64, start pulse -> d_valid exactly 7 cycles after the start edge, acc_out=96000, d_out=1500; busy high for 6 cycles.
3. window all -2048, coeff all 127 -> acc_out=-1300480.
   - Default build: d_out=160 (wrap).
   - With FIR1D_ROUND_SAT_EN: d_out=-2048, sat_flag=1.
4. start pulses on every cycle of an active request, and window changed the cycle after capture -> exactly one d_valid per accepted start; result uses only the captured window.
5. Alternating coeff [64,-64,64,-64,64], window [10,20,30,40,50] -> acc_out=1920, d_out=30. With the macro, a FracBits rounding case: acc=32 -> d_out=1 (default build 0).
6. rst asserted on the 3rd MAC cycle -> no d_valid; d_out=0, busy=0 next cycle. A new start then gives a correct result.
